// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters,
// with a registered operand stage and a registered valid/ready response port.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int TAGW = 4,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_rs1,
  input  logic [32*NREQ-1:0]   req_rs2,
  input  logic [TAGW*NREQ-1:0] req_tag,
  output logic [3:0]           alu_op,
  output logic [31:0]          alu_rs1,
  output logic [31:0]          alu_rs2,
  input  logic [31:0]          alu_rd,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag,
  output logic [31:0]          rsp_rd,
  output logic                 rsp_overflow
);

  // Op encodings shared with the ALU instance.
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  localparam int IDW_EXP = (NREQ <= 2) ? 1 : $clog2(NREQ);

  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("alu_arbiter: NREQ must be in 2..4");
  end
  if (IDW != IDW_EXP) begin : g_bad_idw
    $error("alu_arbiter: IDW must equal max(1, clog2(NREQ))");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IDW-1:0]    ptr_r;
  logic [IDW-1:0]    ptr_nxt_s;
  logic [IDW-1:0]    win_s;
  logic              win_vld_s;
  logic              arb_en_s;
  logic              accept_s;
  logic [3:0]        sel_op_s;
  logic [31:0]       sel_rs1_s;
  logic [31:0]       sel_rs2_s;
  logic [TAGW-1:0]   sel_tag_s;
  logic [3:0]        op_r;
  logic [31:0]       rs1_r;
  logic [31:0]       rs2_r;
  logic [TAGW-1:0]   tag_r;
  logic [IDW-1:0]    id_r;

  // Overflow is only meaningful for add/sub; everything else reports 0.
  function automatic logic ov_mask(input logic [3:0] op, input logic ov);
    logic res;
    case (op)
      ALU_ADD: res = ov;
      ALU_SUB: res = ov;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Circular priority search starting at ptr (or at 0 in fixed-priority builds).
  always_comb begin
    win_s     = '0;
    win_vld_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
`ifdef ALU_ARB_FIXED_PRIO_EN
      j = i;
`else
      j = int'(ptr_r) + i;
      if (j >= NREQ) begin
        j = j - NREQ;
      end else begin
        j = j;
      end
`endif
      if (!win_vld_s && req_valid[j]) begin
        win_vld_s = 1'b1;
        win_s     = j[IDW-1:0];
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // Arbitration is open in IDLE and on the response handshake cycle only.
  always_comb begin
    arb_en_s = 1'b0;
    if (!rst_n) begin
      arb_en_s = 1'b0;
    end else if (state_r == IDLE) begin
      arb_en_s = 1'b1;
    end else if (state_r == RESP) begin
      arb_en_s = rsp_ready;
    end else begin
      arb_en_s = 1'b0;
    end
    accept_s = arb_en_s & win_vld_s;
  end

  // Next pointer is the slot after the winner, wrapping at NREQ-1.
  always_comb begin
    ptr_nxt_s = ptr_r;
`ifdef ALU_ARB_FIXED_PRIO_EN
    ptr_nxt_s = '0;
`else
    if (!accept_s) begin
      ptr_nxt_s = ptr_r;
    end else if (int'(win_s) == NREQ - 1) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = win_s + {{(IDW-1){1'b0}}, 1'b1};
    end
`endif
  end

  // Winner's request fields.
  always_comb begin
    sel_op_s  = req_op[int'(win_s)*4 +: 4];
    sel_rs1_s = req_rs1[int'(win_s)*32 +: 32];
    sel_rs2_s = req_rs2[int'(win_s)*32 +: 32];
    sel_tag_s = req_tag[int'(win_s)*TAGW +: TAGW];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (!rsp_ready) begin
          state_nxt_s = RESP;
        end else if (accept_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant output: one-hot winner on an accept cycle, otherwise all low.
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Operand stage; the ALU is driven straight from these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= 4'h0;
      rs1_r <= 32'h0;
      rs2_r <= 32'h0;
      tag_r <= '0;
      id_r  <= '0;
    end else if (accept_s) begin
      op_r  <= sel_op_s;
      rs1_r <= sel_rs1_s;
      rs2_r <= sel_rs2_s;
      tag_r <= sel_tag_s;
      id_r  <= win_s;
    end
  end

  assign alu_op  = op_r;
  assign alu_rs1 = rs1_r;
  assign alu_rs2 = rs2_r;

  // Response stage: capture in EXEC, hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_tag      <= '0;
      rsp_rd       <= 32'h0;
      rsp_overflow <= 1'b0;
    end else if (state_r == EXEC) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= id_r;
      rsp_tag      <= tag_r;
      rsp_rd       <= alu_rd;
      rsp_overflow <= ov_mask(op_r, alu_overflow);
    end else if (state_r == RESP && rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

endmodule
